// File: rtl/ysyx_22050019_ifu.sv
// Instruction fetch unit: PC owner, single-outstanding I-mem request, IDU handshake.
// Optional misaligned-redirect trap is built when YSYX_22050019_IFU_ALIGN_CHECK_EN is defined.
module ysyx_22050019_ifu #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [63:0] req_addr,
  input  logic        rsp_valid,
  input  logic [63:0] rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_o,
  output logic [63:0] inst_addr_pc_o,
  input  logic        inst_j,
  input  logic [63:0] snpc,
  output logic        fetch_err,
  output logic [63:0] inst_cnt
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3
`ifdef YSYX_22050019_IFU_ALIGN_CHECK_EN
    , ERR = 3'd4
`endif
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [ILEN-1:0] inst_nxt;
  logic [XLEN-1:0] cnt_nxt;
  logic            hs_c;
  logic            bad_target_c;

  assign hs_c           = (state == HOLD) && inst_ready;
  assign bad_target_c   = inst_j && (snpc[1:0] != 2'b00);
  assign req_addr       = {pc[XLEN-1:3], 3'b000};
  assign inst_addr_pc_o = pc;

  // State register plus registered handshake flags and datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      inst_o     <= NOP;
      inst_cnt   <= '0;
      req_valid  <= 1'b0;
      inst_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      inst_o     <= inst_nxt;
      inst_cnt   <= cnt_nxt;
      req_valid  <= (state_nxt == REQ);
      inst_valid <= (state_nxt == HOLD);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = REQ;
      REQ:  if (req_ready) state_nxt = WAIT;
      WAIT: if (rsp_valid) state_nxt = HOLD;
      HOLD: begin
        if (inst_ready) begin
`ifdef YSYX_22050019_IFU_ALIGN_CHECK_EN
          state_nxt = bad_target_c ? ERR : REQ;
`else
          state_nxt = REQ;
`endif
        end
      end
`ifdef YSYX_22050019_IFU_ALIGN_CHECK_EN
      ERR:  state_nxt = ERR;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath next values: word select on response, PC/count update on IDU handshake
  always_comb begin
    pc_nxt   = pc;
    inst_nxt = inst_o;
    cnt_nxt  = inst_cnt;
    if ((state == WAIT) && rsp_valid)
      inst_nxt = pc[2] ? rsp_data[63:32] : rsp_data[31:0];
    if (hs_c) begin
      cnt_nxt = inst_cnt + 64'd1;
      if (inst_j) begin
`ifdef YSYX_22050019_IFU_ALIGN_CHECK_EN
        pc_nxt = snpc;
`else
        pc_nxt = snpc & ~64'd3;
`endif
      end else begin
        pc_nxt = pc + 64'd4;
      end
    end
  end

`ifdef YSYX_22050019_IFU_ALIGN_CHECK_EN
  logic err_q;

  // Sticky error flag, set on the handshake that redirects to a misaligned target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     err_q <= 1'b0;
    else if (hs_c && bad_target_c)  err_q <= 1'b1;
  end

  assign fetch_err = err_q;
`else
  logic unused_c;
  assign unused_c  = bad_target_c;
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22050019_ifu.sv
// Table-driven bench for ysyx_22050019_ifu with a response scoreboard queue.
module tb_ysyx_22050019_ifu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [63:0] req_addr;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_o;
  logic [63:0] inst_addr_pc_o;
  logic        inst_j;
  logic [63:0] snpc;
  logic        fetch_err;
  logic [63:0] inst_cnt;

  ysyx_22050019_ifu #(.RESET_PC(64'h8000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_o(inst_o), .inst_addr_pc_o(inst_addr_pc_o),
    .inst_j(inst_j), .snpc(snpc),
    .fetch_err(fetch_err), .inst_cnt(inst_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rsp;
    logic        j;
    logic [63:0] tgt;
    int          req_wait;
    int          inst_wait;
    logic [63:0] exp_pc;
    logic [63:0] exp_addr;
    logic [31:0] exp_inst;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } exp_t;

`ifdef YSYX_22050019_IFU_ALIGN_CHECK_EN
  localparam int NV = 8;
`else
  localparam int NV = 9;
`endif

  vec_t        vecs [NV];
  exp_t        sb [$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " req_valid"}, 64'(req_valid), 64'd0);
    chk({tag, " inst_valid"}, 64'(inst_valid), 64'd0);
    chk({tag, " inst_o"}, 64'(inst_o), 64'h13);
    chk({tag, " pc"}, inst_addr_pc_o, 64'h8000_0000);
    chk({tag, " inst_cnt"}, inst_cnt, 64'd0);
    chk({tag, " fetch_err"}, 64'(fetch_err), 64'd0);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_valid) begin
      n_vec++;
      n_err++;
      $display("FAIL req_timeout: got req_valid=0 want 1 within 20 cycles");
    end
  endtask

  task automatic do_txn(input vec_t v, input int idx);
    exp_t e;
    logic exp_err;
    wait_req();
    chk($sformatf("v%0d req_addr", idx), req_addr, v.exp_addr);
    for (int i = 0; i < v.req_wait; i++) begin
      req_ready = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d req_hold_valid", idx), 64'(req_valid), 64'd1);
      chk($sformatf("v%0d req_hold_addr", idx), req_addr, v.exp_addr);
    end
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    chk($sformatf("v%0d wait_req_valid", idx), 64'(req_valid), 64'd0);
    sb.push_back('{inst: v.exp_inst, pc: v.exp_pc});
    rsp_valid = 1'b1;
    rsp_data  = v.rsp;
    @(negedge clk);
    rsp_valid = 1'b0;
    rsp_data  = 64'h0;
    chk($sformatf("v%0d inst_valid", idx), 64'(inst_valid), 64'd1);
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL v%0d scoreboard: got empty queue want an entry", idx);
    end else begin
      e = sb.pop_front();
      chk($sformatf("v%0d inst_o", idx), 64'(inst_o), 64'(e.inst));
      chk($sformatf("v%0d inst_pc", idx), inst_addr_pc_o, e.pc);
    end
    for (int i = 0; i < v.inst_wait; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d hold_valid", idx), 64'(inst_valid), 64'd1);
      chk($sformatf("v%0d hold_inst", idx), 64'(inst_o), 64'(v.exp_inst));
      chk($sformatf("v%0d hold_cnt", idx), inst_cnt, exp_cnt);
    end
    inst_ready = 1'b1;
    inst_j     = v.j;
    snpc       = v.tgt;
    @(negedge clk);
    inst_ready = 1'b0;
    inst_j     = 1'b0;
    snpc       = 64'h0;
    exp_cnt    = exp_cnt + 64'd1;
`ifdef YSYX_22050019_IFU_ALIGN_CHECK_EN
    exp_err = v.j && (v.tgt[1:0] != 2'b00);
`else
    exp_err = 1'b0;
`endif
    chk($sformatf("v%0d inst_cnt", idx), inst_cnt, exp_cnt);
    chk($sformatf("v%0d post_hs_valid", idx), 64'(inst_valid), 64'd0);
    chk($sformatf("v%0d fetch_err", idx), 64'(fetch_err), 64'(exp_err));
  endtask

  initial begin
    vecs[0] = '{64'h0000_0073_0010_0093, 1'b0, 64'h0,                  0, 0, 64'h8000_0000,         64'h8000_0000,         32'h0010_0093};
    vecs[1] = '{64'h0000_0073_0010_0093, 1'b0, 64'h0,                  0, 0, 64'h8000_0004,         64'h8000_0000,         32'h0000_0073};
    vecs[2] = '{64'h1111_2222_3333_4444, 1'b0, 64'h0,                  0, 0, 64'h8000_0008,         64'h8000_0008,         32'h3333_4444};
    vecs[3] = '{64'h5555_6666_7777_8888, 1'b1, 64'h8000_0100,          0, 0, 64'h8000_000C,         64'h8000_0008,         32'h5555_6666};
    vecs[4] = '{64'h9999_AAAA_BBBB_CCCC, 1'b0, 64'h8000_0200,          0, 0, 64'h8000_0100,         64'h8000_0100,         32'hBBBB_CCCC};
    vecs[5] = '{64'hDEAD_BEEF_0BAD_F00D, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 5, 4, 64'h8000_0104,         64'h8000_0100,         32'hDEAD_BEEF};
    vecs[6] = '{64'h0123_4567_89AB_CDEF, 1'b0, 64'h0,                  0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF8, 32'h0123_4567};
    vecs[7] = '{64'hCAFE_0001_FACE_0002, 1'b1, 64'h8000_0102,          0, 0, 64'h0,                 64'h0,                 32'hFACE_0002};
`ifndef YSYX_22050019_IFU_ALIGN_CHECK_EN
    vecs[8] = '{64'h0000_1111_0000_2222, 1'b0, 64'h0,                  0, 0, 64'h8000_0100,         64'h8000_0100,         32'h0000_2222};
`endif

    rst_n      = 1'b0;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_data   = 64'h0;
    inst_ready = 1'b0;
    inst_j     = 1'b0;
    snpc       = 64'h0;
    exp_cnt    = 64'd0;
    repeat (3) @(negedge clk);
    chk_reset_vals("por");
    rst_n = 1'b1;

    // Reset asserted in WAIT, then a stale response one cycle after release
    wait_req();
    chk("pre_rst req_addr", req_addr, 64'h8000_0000);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rsp_valid = 1'b1;
    rsp_data  = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    rsp_valid = 1'b0;
    rsp_data  = 64'h0;
    chk("stale inst_valid", 64'(inst_valid), 64'd0);
    chk("stale inst_o", 64'(inst_o), 64'h13);
    chk("stale req_valid", 64'(req_valid), 64'd1);
    chk("stale req_addr", req_addr, 64'h8000_0000);

    for (int k = 0; k < NV; k++) do_txn(vecs[k], k);

`ifdef YSYX_22050019_IFU_ALIGN_CHECK_EN
    chk("err pc", inst_addr_pc_o, 64'h8000_0102);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("err req_valid", 64'(req_valid), 64'd0);
      chk("err inst_valid", 64'(inst_valid), 64'd0);
      chk("err sticky", 64'(fetch_err), 64'd1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
